// File: rtl/brick_pkg.sv
// Shared constants, types and helpers for the brick hit updater.
// Holds grid geometry, colour codes, FSM encoding and the queued hit payload.
package brick_pkg;

  localparam int unsigned BRICK_W_SHIFT = 4;
  localparam int unsigned BRICK_H_SHIFT = 3;
  localparam int unsigned GRID_COLS     = 20;
  localparam int unsigned GRID_ROWS     = 30;
  localparam int unsigned NUM_BRICKS    = 600;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned HEALTH_W = 2;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned SCORE_W  = 16;
  localparam int unsigned COL_W    = COORD_W - BRICK_W_SHIFT;
  localparam int unsigned ROW_W    = COORD_W - BRICK_H_SHIFT;

  localparam logic [COLOUR_W-1:0] COLOUR_H3 = 3'b100;
  localparam logic [COLOUR_W-1:0] COLOUR_H2 = 3'b110;
  localparam logic [COLOUR_W-1:0] COLOUR_H1 = 3'b010;
  localparam logic [COLOUR_W-1:0] COLOUR_H0 = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CHK  = 3'd2,
    ST_WR   = 3'd3,
    ST_DRAW = 3'd4
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
  } hit_entry_t;

  // Pixel coordinates to grid cell and RAM address for a grid 'cols' wide.
  function automatic hit_entry_t decode_hit(input logic [COORD_W-1:0] x,
                                            input logic [COORD_W-1:0] y,
                                            input int unsigned cols);
    hit_entry_t e;
    e.col  = COL_W'(x >> BRICK_W_SHIFT);
    e.row  = ROW_W'(y >> BRICK_H_SHIFT);
    e.addr = ADDR_W'(32'(e.row) * cols + 32'(e.col));
    return e;
  endfunction

  function automatic logic [COLOUR_W-1:0] health_colour(input logic [HEALTH_W-1:0] h);
    case (h)
      2'd3:    return COLOUR_H3;
      2'd2:    return COLOUR_H2;
      2'd1:    return COLOUR_H1;
      default: return COLOUR_H0;
    endcase
  endfunction

endpackage

// File: rtl/brick_hit_updater_if.sv
// Collision-report, health-RAM, VGA-draw and status signals of the hit updater.
// slave is the updater's view, master is the surrounding game logic's view.
interface brick_hit_updater_if;
  import brick_pkg::*;

  logic                hit1_valid;
  logic                hit2_valid;
  logic [COORD_W-1:0]  hit1_x;
  logic [COORD_W-1:0]  hit1_y;
  logic [COORD_W-1:0]  hit2_x;
  logic [COORD_W-1:0]  hit2_y;

  logic [ADDR_W-1:0]   mem_addr;
  logic [HEALTH_W-1:0] mem_rdata;
  logic                mem_we;
  logic [HEALTH_W-1:0] mem_wdata;

  logic                draw_req;
  logic                draw_ack;
  logic [COORD_W-1:0]  draw_x;
  logic [COORD_W-1:0]  draw_y;
  logic [COLOUR_W-1:0] draw_colour;

  logic [SCORE_W-1:0]  score;
  logic [ADDR_W-1:0]   bricks_left;
  logic                level_clear;
  logic                busy;
  logic                overflow;

  modport slave (
    input  hit1_valid, hit2_valid, hit1_x, hit1_y, hit2_x, hit2_y,
    input  mem_rdata, draw_ack,
    output mem_addr, mem_we, mem_wdata,
    output draw_req, draw_x, draw_y, draw_colour,
    output score, bricks_left, level_clear, busy, overflow
  );

  modport master (
    output hit1_valid, hit2_valid, hit1_x, hit1_y, hit2_x, hit2_y,
    output mem_rdata, draw_ack,
    input  mem_addr, mem_we, mem_wdata,
    input  draw_req, draw_x, draw_y, draw_colour,
    input  score, bricks_left, level_clear, busy, overflow
  );

endinterface

// File: rtl/hit_fifo.sv
// Two-entry hit queue with two ordered push ports and one pop port.
// A pop frees its slot in the same cycle, so a full queue that pops can still take one push.
module hit_fifo
  import brick_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       push0,
  input  hit_entry_t din0,
  input  logic       push1,
  input  hit_entry_t din1,
  input  logic       pop,
  output hit_entry_t head,
  output logic       empty,
  output logic       drop
);

  localparam int unsigned DEPTH = 2;

  hit_entry_t mem_q [DEPTH];
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       pop_ok;
  logic       acc0;
  logic       acc1;
  logic [1:0] space;
  logic       wr_ptr0;
  logic       wr_ptr1;

  // push0 always takes the first free slot, push1 the one after it
  always_comb begin
    pop_ok  = pop && (count_q != 2'd0);
    space   = 2'(DEPTH) - count_q + {1'b0, pop_ok};
    acc0    = push0 && (space != 2'd0);
    acc1    = push1 && (space > (acc0 ? 2'd1 : 2'd0));
    drop    = (push0 && !acc0) || (push1 && !acc1);
    wr_ptr0 = rd_ptr_q ^ count_q[0];
    wr_ptr1 = wr_ptr0 ^ acc0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_q ^ pop_ok;
      count_q  <= count_q - {1'b0, pop_ok} + {1'b0, acc0} + {1'b0, acc1};
    end
  end

  always_ff @(posedge clk) begin
    if (acc0) mem_q[wr_ptr0] <= din0;
    if (acc1) mem_q[wr_ptr1] <= din1;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/brick_hit_updater.sv
// Turns ball/brick collision reports into health-RAM read-modify-writes, redraw
// requests and score/brick-count updates, one queued report at a time.
module brick_hit_updater #(
  parameter int unsigned GRID_COLS  = brick_pkg::GRID_COLS,
  parameter int unsigned GRID_ROWS  = brick_pkg::GRID_ROWS,
  parameter int unsigned NUM_BRICKS = brick_pkg::NUM_BRICKS
) (
  input logic                clk,
  input logic                resetn,
  brick_hit_updater_if.slave bus
);
  import brick_pkg::*;

  hit_entry_t e1;
  hit_entry_t e2;
  logic       ok1;
  logic       ok2;
  logic       push2;
  hit_entry_t head;
  logic       fifo_empty;
  logic       fifo_drop;
  logic       pop;

  state_t              state_q, state_d;
  hit_entry_t          cur_q, cur_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [HEALTH_W-1:0] mem_wdata_q, mem_wdata_d;
  logic                draw_req_q, draw_req_d;
  logic [COORD_W-1:0]  draw_x_q, draw_x_d;
  logic [COORD_W-1:0]  draw_y_q, draw_y_d;
  logic [COLOUR_W-1:0] draw_colour_q, draw_colour_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [ADDR_W-1:0]   bricks_left_q, bricks_left_d;
  logic                overflow_q, overflow_d;

  // Off-grid reports are discarded; a duplicate second report in the same cycle is folded
  always_comb begin
    e1    = decode_hit(bus.hit1_x, bus.hit1_y, GRID_COLS);
    e2    = decode_hit(bus.hit2_x, bus.hit2_y, GRID_COLS);
    ok1   = bus.hit1_valid && (32'(e1.col) < GRID_COLS) && (32'(e1.row) < GRID_ROWS);
    ok2   = bus.hit2_valid && (32'(e2.col) < GRID_COLS) && (32'(e2.row) < GRID_ROWS);
    push2 = ok2 && !(ok1 && (e1.addr == e2.addr));
  end

  hit_fifo u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push0  (ok1),
    .din0   (e1),
    .push1  (push2),
    .din1   (e2),
    .pop    (pop),
    .head   (head),
    .empty  (fifo_empty),
    .drop   (fifo_drop)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cur_q         <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      draw_req_q    <= 1'b0;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      draw_colour_q <= '0;
      score_q       <= '0;
      bricks_left_q <= ADDR_W'(NUM_BRICKS);
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      draw_req_q    <= draw_req_d;
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      draw_colour_q <= draw_colour_d;
      score_q       <= score_d;
      bricks_left_q <= bricks_left_d;
      overflow_q    <= overflow_d;
    end
  end

  // IDLE also starts on a report arriving this cycle so RD follows the report directly
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = 1'b0;
    mem_wdata_d   = mem_wdata_q;
    draw_req_d    = draw_req_q;
    draw_x_d      = draw_x_q;
    draw_y_d      = draw_y_q;
    draw_colour_d = draw_colour_q;
    score_d       = score_q;
    bricks_left_d = bricks_left_q;
    overflow_d    = overflow_q | fifo_drop;
    pop           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          cur_d      = head;
          mem_addr_d = head.addr;
          state_d    = ST_RD;
        end else if (ok1) begin
          cur_d      = e1;
          mem_addr_d = e1.addr;
          state_d    = ST_RD;
        end else if (push2) begin
          cur_d      = e2;
          mem_addr_d = e2.addr;
          state_d    = ST_RD;
        end
      end
      ST_RD: state_d = ST_CHK;
      ST_CHK: begin
        if (bus.mem_rdata == '0) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          mem_we_d    = 1'b1;
          mem_wdata_d = bus.mem_rdata - HEALTH_W'(1);
          if (bus.mem_rdata == HEALTH_W'(1)) begin
            score_d       = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
            bricks_left_d = (bricks_left_q == '0) ? bricks_left_q : bricks_left_q - ADDR_W'(1);
          end
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        draw_req_d    = 1'b1;
        draw_x_d      = COORD_W'(cur_q.col) << BRICK_W_SHIFT;
        draw_y_d      = COORD_W'(cur_q.row) << BRICK_H_SHIFT;
        draw_colour_d = health_colour(mem_wdata_q);
        state_d       = ST_DRAW;
      end
      ST_DRAW: begin
        if (bus.draw_ack) begin
          pop        = 1'b1;
          draw_req_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.draw_req    = draw_req_q;
  assign bus.draw_x      = draw_x_q;
  assign bus.draw_y      = draw_y_q;
  assign bus.draw_colour = draw_colour_q;
  assign bus.score       = score_q;
  assign bus.bricks_left = bricks_left_q;
  assign bus.overflow    = overflow_q;
  assign bus.level_clear = (bricks_left_q == '0);
  assign bus.busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_brick_hit_updater.sv
// Bench for brick_hit_updater: health-RAM model, draw_ack responder and a
// write/draw scoreboard checked every cycle from the main test sequence.
module tb_brick_hit_updater;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  brick_hit_updater_if bus ();

  brick_hit_updater #(.GRID_COLS(20), .GRID_ROWS(30), .NUM_BRICKS(600)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int x; int y; int c; } dr_t;

  wr_t exp_wr[$];
  dr_t exp_dr[$];
  int  checks = 0;
  int  errors = 0;

  logic [1:0] ram [1024];
  logic       pl_we = 1'b0;
  logic [9:0] pl_addr = '0;
  logic [1:0] pl_data = '0;
  int         ack_delay = 2;
  logic       ack_hold = 1'b0;
  int         ack_cnt = 0;

  logic       we_prev = 1'b0;
  logic       req_prev = 1'b0;
  logic [9:0] px = '0;
  logic [9:0] py = '0;
  logic [2:0] pc = '0;

  always @(posedge clk) begin
    bus.mem_rdata <= ram[bus.mem_addr];
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
  end

  always @(negedge clk) begin
    if (!bus.draw_req || bus.draw_ack) begin
      bus.draw_ack <= 1'b0;
      ack_cnt      <= 0;
    end else if (!ack_hold) begin
      if (ack_cnt + 1 >= ack_delay) bus.draw_ack <= 1'b1;
      ack_cnt <= ack_cnt + 1;
    end
  end

  function automatic int exp_colour(input int h);
    case (h)
      3: return 3'b100;
      2: return 3'b110;
      1: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Advance one cycle and compare any write or draw the DUT produces against the scoreboard
  task automatic tick();
    wr_t w;
    dr_t d;
    @(negedge clk);
    if (resetn && bus.mem_we) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%0d", bus.mem_addr, bus.mem_wdata);
      end else begin
        w = exp_wr.pop_front();
        if (we_prev || 32'(bus.mem_addr) !== w.addr || 32'(bus.mem_wdata) !== w.data) begin
          errors++;
          $display("FAIL write got addr=%0d data=%0d prev_we=%0b expected addr=%0d data=%0d",
                   bus.mem_addr, bus.mem_wdata, we_prev, w.addr, w.data);
        end
      end
    end
    if (resetn && bus.draw_req && !req_prev) begin
      checks++;
      if (exp_dr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_draw x=%0d y=%0d c=%b", bus.draw_x, bus.draw_y, bus.draw_colour);
      end else begin
        d = exp_dr.pop_front();
        if (32'(bus.draw_x) !== d.x || 32'(bus.draw_y) !== d.y || 32'(bus.draw_colour) !== d.c) begin
          errors++;
          $display("FAIL draw got x=%0d y=%0d c=%b expected x=%0d y=%0d c=%b",
                   bus.draw_x, bus.draw_y, bus.draw_colour, d.x, d.y, d.c[2:0]);
        end
      end
    end else if (resetn && bus.draw_req && req_prev) begin
      checks++;
      if ({bus.draw_x, bus.draw_y, bus.draw_colour} !== {px, py, pc}) begin
        errors++;
        $display("FAIL draw_stable got x=%0d y=%0d c=%b required x=%0d y=%0d c=%b",
                 bus.draw_x, bus.draw_y, bus.draw_colour, px, py, pc);
      end
    end
    we_prev  = bus.mem_we;
    req_prev = bus.draw_req;
    px = bus.draw_x;
    py = bus.draw_y;
    pc = bus.draw_colour;
  endtask

  task automatic preload(input int addr, input int h);
    pl_we   = 1'b1;
    pl_addr = 10'(addr);
    pl_data = 2'(h);
    tick();
    pl_we   = 1'b0;
  endtask

  task automatic expect_hit(input int x, input int y, input int old_h);
    exp_wr.push_back('{addr: (y >> 3) * 20 + (x >> 4), data: old_h - 1});
    exp_dr.push_back('{x: (x >> 4) << 4, y: (y >> 3) << 3, c: exp_colour(old_h - 1)});
  endtask

  task automatic hit(input bit v1, input int x1, input int y1,
                     input bit v2, input int x2, input int y2);
    bus.hit1_valid = v1;
    bus.hit1_x = 10'(x1);
    bus.hit1_y = 10'(y1);
    bus.hit2_valid = v2;
    bus.hit2_x = 10'(x2);
    bus.hit2_y = 10'(y2);
    tick();
    bus.hit1_valid = 1'b0;
    bus.hit2_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget && (bus.busy || bus.draw_req); i++) tick();
    checks++;
    if (bus.busy || bus.draw_req) begin
      errors++;
      $display("FAIL %s_idle_timeout busy=%0b draw_req=%0b required 0", name, bus.busy, bus.draw_req);
    end
  endtask

  task automatic wait_draw(input int budget, input string name);
    for (int i = 0; i < budget && !bus.draw_req; i++) tick();
    checks++;
    if (!bus.draw_req) begin
      errors++;
      $display("FAIL %s_draw_timeout draw_req=0 required 1", name);
    end
  endtask

  task automatic check_queues(input string name);
    checks++;
    if (exp_wr.size() != 0 || exp_dr.size() != 0) begin
      errors++;
      $display("FAIL %s_pending writes=%0d draws=%0d required 0", name, exp_wr.size(), exp_dr.size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    checks++;
    if (bus.score !== 16'd0 || bus.bricks_left !== 10'd600) begin
      errors++;
      $display("FAIL reset_counts score=%0d bricks=%0d required 0/600", bus.score, bus.bricks_left);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.overflow !== 1'b0 || bus.level_clear !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%0b overflow=%0b level_clear=%0b required 0",
               bus.busy, bus.overflow, bus.level_clear);
    end
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 10'd0 || bus.mem_wdata !== 2'd0 || bus.draw_req !== 1'b0 ||
        bus.draw_x !== 10'd0 || bus.draw_y !== 10'd0 || bus.draw_colour !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs we=%0b addr=%0d wdata=%0d req=%0b x=%0d y=%0d c=%0d required all 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.draw_req, bus.draw_x, bus.draw_y, bus.draw_colour);
    end
  endtask

  task automatic test_single_hit();
    preload(42, 3);
    ack_delay = 2;
    expect_hit(32, 16, 3);
    hit(1, 32, 16, 0, 0, 0);
    checks++;
    if (bus.mem_addr !== 10'd42 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_rd addr=%0d busy=%0b required 42/1", bus.mem_addr, bus.busy);
    end
    tick();
    tick();
    checks++;
    if (bus.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL single_wr_latency mem_we=%0b required 1", bus.mem_we);
    end
    tick();
    checks++;
    if (bus.draw_req !== 1'b1) begin
      errors++;
      $display("FAIL single_draw_latency draw_req=%0b required 1", bus.draw_req);
    end
    wait_idle(40, "single");
    checks++;
    if (bus.score !== 16'd0 || bus.bricks_left !== 10'd600 || ram[42] !== 2'd2) begin
      errors++;
      $display("FAIL single_after score=%0d bricks=%0d ram42=%0d required 0/600/2",
               bus.score, bus.bricks_left, ram[42]);
    end
    check_queues("single");
  endtask

  task automatic test_same_addr();
    preload(23, 1);
    expect_hit(48, 8, 1);
    hit(1, 48, 8, 1, 48, 8);
    wait_idle(40, "same_addr");
    checks++;
    if (bus.score !== 16'd1 || bus.bricks_left !== 10'd599 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL same_addr_counts score=%0d bricks=%0d overflow=%0b required 1/599/0",
               bus.score, bus.bricks_left, bus.overflow);
    end
    check_queues("same_addr");
  endtask

  task automatic test_back_to_back();
    preload(20, 2);
    preload(41, 3);
    ack_delay = 1;
    expect_hit(0, 8, 2);
    expect_hit(16, 16, 3);
    hit(1, 0, 8, 1, 16, 16);
    wait_idle(60, "b2b");
    check_queues("b2b");
    checks++;
    if (ram[20] !== 2'd1 || ram[41] !== 2'd2) begin
      errors++;
      $display("FAIL b2b_ram ram20=%0d ram41=%0d required 1/2", ram[20], ram[41]);
    end
  endtask

  task automatic test_stale();
    preload(64, 0);
    hit(1, 64, 24, 0, 0, 0);
    checks++;
    if (bus.busy !== 1'b1 || bus.mem_addr !== 10'd64) begin
      errors++;
      $display("FAIL stale_start busy=%0b addr=%0d required 1/64", bus.busy, bus.mem_addr);
    end
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.draw_req !== 1'b0) begin
      errors++;
      $display("FAIL stale_pop busy=%0b draw_req=%0b required 0/0", bus.busy, bus.draw_req);
    end
    repeat (3) tick();
  endtask

  task automatic test_out_of_range();
    hit(1, 400, 0, 1, 0, 240);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL range_busy busy=%0b required 0", bus.busy);
    end
    repeat (4) tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL range_after busy=%0b overflow=%0b required 0/0", bus.busy, bus.overflow);
    end
  endtask

  task automatic test_overflow();
    preload(200, 2);
    preload(201, 2);
    preload(202, 2);
    ack_hold  = 1'b1;
    ack_delay = 2;
    expect_hit(0, 80, 2);
    hit(1, 0, 80, 0, 0, 0);
    wait_draw(20, "ovf");
    expect_hit(16, 80, 2);
    hit(1, 16, 80, 0, 0, 0);
    hit(1, 32, 80, 0, 0, 0);
    checks++;
    if (bus.overflow !== 1'b1 || bus.busy !== 1'b1 || bus.draw_req !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag overflow=%0b busy=%0b draw_req=%0b required 1/1/1",
               bus.overflow, bus.busy, bus.draw_req);
    end
    ack_hold = 1'b0;
    wait_idle(80, "ovf");
    check_queues("ovf");
    checks++;
    if (ram[202] !== 2'd2 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop ram202=%0d overflow=%0b required 2/1", ram[202], bus.overflow);
    end
  endtask

  task automatic test_reset_mid();
    preload(300, 1);
    ack_hold = 1'b1;
    expect_hit(0, 120, 1);
    hit(1, 0, 120, 0, 0, 0);
    wait_draw(20, "rst_mid");
    checks++;
    if (bus.score !== 16'd2 || bus.bricks_left !== 10'd598) begin
      errors++;
      $display("FAIL rst_mid_before score=%0d bricks=%0d required 2/598", bus.score, bus.bricks_left);
    end
    resetn = 1'b0;
    tick();
    checks++;
    if (bus.draw_req !== 1'b0 || bus.score !== 16'd0 || bus.bricks_left !== 10'd600 ||
        bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid req=%0b score=%0d bricks=%0d busy=%0b ovf=%0b required 0/0/600/0/0",
               bus.draw_req, bus.score, bus.bricks_left, bus.busy, bus.overflow);
    end
    resetn   = 1'b1;
    ack_hold = 1'b0;
    repeat (6) tick();
    checks++;
    if (bus.draw_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after req=%0b busy=%0b required 0/0", bus.draw_req, bus.busy);
    end
    check_queues("rst_mid");
  endtask

  initial begin
    resetn         = 1'b0;
    bus.hit1_valid = 1'b0;
    bus.hit2_valid = 1'b0;
    bus.hit1_x     = '0;
    bus.hit1_y     = '0;
    bus.hit2_x     = '0;
    bus.hit2_y     = '0;
    test_reset();
    test_single_hit();
    test_same_addr();
    test_back_to_back();
    test_stale();
    test_out_of_range();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
